// File: rtl/fft_r2sdf_stage.sv
// rtl/fft_r2sdf_stage.sv - radix-2 DIF single-path delay-feedback FFT stage
// Optional FFT_SDF_ROUND_EN: round-half-up in butterfly and twiddle multiply instead of truncation.

package fft_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int TWIDDLE_WIDTH = 9;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } complex_t;

  typedef struct packed {
    logic signed [TWIDDLE_WIDTH-1:0] cos;
    logic signed [TWIDDLE_WIDTH-1:0] sin;
  } twiddle_t;
endpackage

module fft_r2sdf_stage
  import fft_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int TW_ADDR_W = 8,
  parameter int TW_STRIDE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  complex_t             in_data,
  output logic [TW_ADDR_W-1:0] tw_addr,
  input  twiddle_t             tw_data,
  output logic                 out_valid,
  output complex_t             out_data,
  output logic                 out_sop
);

  localparam int CW = $clog2(2 * DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef FFT_SDF_ROUND_EN
  localparam int BW = DATA_WIDTH + 2;
  localparam int MW = DATA_WIDTH + TWIDDLE_WIDTH + 2;
  localparam logic signed [BW-1:0] B_RND = BW'(1);
  localparam logic signed [MW-1:0] M_RND = MW'(64);
`else
  localparam int BW = DATA_WIDTH + 1;
  localparam int MW = DATA_WIDTH + TWIDDLE_WIDTH + 1;
  localparam logic signed [BW-1:0] B_RND = '0;
  localparam logic signed [MW-1:0] M_RND = '0;
`endif

  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr;
  logic          phase_b;
  logic          primed;

  complex_t mem [2**PW];
  complex_t head;
  complex_t sum_c;
  complex_t diff_c;

  complex_t s1_data;
  logic     s1_valid;
  logic     s1_mul;
  logic     s1_sop;

  function automatic logic signed [DATA_WIDTH-1:0] bfly(
    input logic signed [DATA_WIDTH-1:0] f,
    input logic signed [DATA_WIDTH-1:0] x,
    input logic                         sub
  );
    logic signed [BW-1:0] t;
    t = sub ? (BW'(f) - BW'(x)) : (BW'(f) + BW'(x));
    return DATA_WIDTH'((t + B_RND) >>> 1);
  endfunction

  // W = cos - j*sin, so (a + jb)*W = (a*cos + b*sin) + j(b*cos - a*sin)
  function automatic complex_t twiddle_mul(input complex_t v, input twiddle_t w);
    logic signed [MW-1:0] acc_re;
    logic signed [MW-1:0] acc_im;
    complex_t             r;
    acc_re = MW'(v.re) * MW'(w.cos) + MW'(v.im) * MW'(w.sin) + M_RND;
    acc_im = MW'(v.im) * MW'(w.cos) - MW'(v.re) * MW'(w.sin) + M_RND;
    r.re   = DATA_WIDTH'(acc_re >>> 7);
    r.im   = DATA_WIDTH'(acc_im >>> 7);
    return r;
  endfunction

  assign phase_b = cnt[CW-1];
  assign ptr     = (DEPTH == 1) ? '0 : PW'(cnt);
  assign head    = mem[ptr];

  assign sum_c.re  = bfly(head.re, in_data.re, 1'b0);
  assign sum_c.im  = bfly(head.im, in_data.im, 1'b0);
  assign diff_c.re = bfly(head.re, in_data.re, 1'b1);
  assign diff_c.im = bfly(head.im, in_data.im, 1'b1);

  // Delay line is deliberately not reset; priming keeps stale contents from reaching the output.
  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      mem[ptr] <= phase_b ? diff_c : in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      primed    <= 1'b0;
      s1_data   <= '0;
      s1_valid  <= 1'b0;
      s1_mul    <= 1'b0;
      s1_sop    <= 1'b0;
      tw_addr   <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_data  <= '0;
    end else begin
      s1_valid  <= 1'b0;
      out_valid <= s1_valid;
      out_sop   <= s1_valid & s1_sop;
      if (s1_valid) begin
        out_data <= s1_mul ? twiddle_mul(s1_data, tw_data) : s1_data;
      end
      if (in_valid) begin
        cnt <= cnt + CW'(1);
        if (phase_b) begin
          s1_data  <= sum_c;
          s1_mul   <= 1'b0;
          s1_valid <= 1'b1;
          s1_sop   <= (ptr == '0);
          primed   <= 1'b1;
        end else begin
          s1_data  <= head;
          s1_mul   <= 1'b1;
          s1_valid <= primed;
          s1_sop   <= 1'b0;
          tw_addr  <= TW_ADDR_W'(32'(ptr) * TW_STRIDE);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_r2sdf_stage.sv
// tb/tb_fft_r2sdf_stage.sv - directed vector bench for fft_r2sdf_stage (DEPTH=2 and DEPTH=1 instances)
// Rounding expectations follow FFT_SDF_ROUND_EN when it is defined.

module tb_fft_r2sdf_stage;

  typedef struct {
    int                  sel;
    logic                rst_before;
    logic signed [31:0]  re;
    logic signed [31:0]  im;
    logic                ev;
    logic signed [31:0]  ere;
    logic signed [31:0]  eim;
    logic                esop;
    int                  etw;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;

  logic        d2_ov, d2_sop, d1_ov, d1_sop;
  logic [63:0] d2_od, d1_od;
  logic [7:0]  d2_ta, d1_ta;
  logic [17:0] d2_tw, d1_tw;

  logic        o_v, o_sop;
  logic [63:0] o_d;
  logic [7:0]  o_ta;

  int   cur_sel;
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t tbl[$];
  vec_t nul;
  vec_t pexp;

  always #5 clk = ~clk;

  function automatic logic [17:0] rom(input logic [7:0] a);
    case (a)
      8'd0:    rom = {9'd128, 9'd0};
      8'd1:    rom = {9'd0, 9'd128};
      default: rom = '0;
    endcase
  endfunction

  assign d2_tw = rom(d2_ta);
  assign d1_tw = rom(d1_ta);

  fft_r2sdf_stage #(.DEPTH(2), .TW_ADDR_W(8), .TW_STRIDE(1)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .tw_addr(d2_ta), .tw_data(d2_tw),
    .out_valid(d2_ov), .out_data(d2_od), .out_sop(d2_sop)
  );

  fft_r2sdf_stage #(.DEPTH(1), .TW_ADDR_W(8), .TW_STRIDE(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .tw_addr(d1_ta), .tw_data(d1_tw),
    .out_valid(d1_ov), .out_data(d1_od), .out_sop(d1_sop)
  );

  always_comb begin
    o_v   = (cur_sel == 1) ? d1_ov  : d2_ov;
    o_d   = (cur_sel == 1) ? d1_od  : d2_od;
    o_sop = (cur_sel == 1) ? d1_sop : d2_sop;
    o_ta  = (cur_sel == 1) ? d1_ta  : d2_ta;
  end

  function automatic vec_t mk(input int sel, input logic rb, input int re, input int im,
                              input logic ev, input int ere, input int eim,
                              input logic esop, input int etw);
    vec_t v;
    v.sel = sel; v.rst_before = rb; v.re = re; v.im = im;
    v.ev = ev; v.ere = ere; v.eim = eim; v.esop = esop; v.etw = etw;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut depth %0d): got %h expected %h", name, (cur_sel == 1) ? 1 : 2, act, exp);
    end
  endtask

  // The output checked after each edge belongs to the accept one step earlier: 2-cycle latency.
  task automatic step(input logic v, input vec_t e);
    in_valid = v;
    in_data  = {e.re, e.im};
    @(posedge clk);
    @(negedge clk);
    check("out_valid", {63'd0, o_v}, {63'd0, pexp.ev});
    if (pexp.ev) begin
      check("out_data", o_d, {pexp.ere, pexp.eim});
      check("out_sop", {63'd0, o_sop}, {63'd0, pexp.esop});
    end
    if (v && e.etw >= 0) check("tw_addr", {56'd0, o_ta}, {56'd0, e.etw[7:0]});
    if (v) pexp = e;
    else   pexp = nul;
  endtask

  task automatic do_reset();
    step(1'b0, nul);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    pexp = nul;
  endtask

  int basic_lo;
  int rnd_val;

  initial begin
    nul      = mk(2, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, -1);
    pexp     = nul;
    cur_sel  = 2;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef FFT_SDF_ROUND_EN
    rnd_val = 2;
`else
    rnd_val = 1;
`endif

    basic_lo = 0;
    tbl.push_back(mk(2, 1'b1,  4, 0, 1'b0,  0, 0, 1'b0,  0));
    tbl.push_back(mk(2, 1'b0,  8, 0, 1'b0,  0, 0, 1'b0,  1));
    tbl.push_back(mk(2, 1'b0, 12, 0, 1'b1,  8, 0, 1'b1, -1));
    tbl.push_back(mk(2, 1'b0, 16, 0, 1'b1, 12, 0, 1'b0, -1));
    tbl.push_back(mk(2, 1'b0,  4, 0, 1'b1, -4, 0, 1'b0,  0));
    tbl.push_back(mk(2, 1'b0,  8, 0, 1'b1,  0, 4, 1'b0,  1));
    tbl.push_back(mk(2, 1'b0, 12, 0, 1'b1,  8, 0, 1'b1, -1));
    tbl.push_back(mk(2, 1'b0, 16, 0, 1'b1, 12, 0, 1'b0, -1));
    tbl.push_back(mk(2, 1'b0,  0, 0, 1'b1, -4, 0, 1'b0,  0));
    tbl.push_back(mk(2, 1'b0,  0, 0, 1'b1,  0, 4, 1'b0,  1));
    // complex data: im path and the sin terms
    tbl.push_back(mk(2, 1'b1,  0,  0, 1'b0,  0, 0, 1'b0,  0));
    tbl.push_back(mk(2, 1'b0,  2,  6, 1'b0,  0, 0, 1'b0,  1));
    tbl.push_back(mk(2, 1'b0,  4,  0, 1'b1,  2, 0, 1'b1, -1));
    tbl.push_back(mk(2, 1'b0, 10, -2, 1'b1,  6, 2, 1'b0, -1));
    tbl.push_back(mk(2, 1'b0,  0,  0, 1'b1, -2, 0, 1'b0,  0));
    tbl.push_back(mk(2, 1'b0,  0,  0, 1'b1,  4, 4, 1'b0,  1));
    // DEPTH=1 full-scale sum must not overflow
    tbl.push_back(mk(1, 1'b1, 32'h7FFFFFFF, 0, 1'b0, 0, 0, 1'b0, 0));
    tbl.push_back(mk(1, 1'b0, 32'h7FFFFFFF, 0, 1'b1, 32'h7FFFFFFF, 0, 1'b1, -1));
    tbl.push_back(mk(1, 1'b0, 0, 0, 1'b1, 0, 0, 1'b0, 0));
    // odd values expose truncation versus rounding
    tbl.push_back(mk(1, 1'b1, 3, 0, 1'b0, 0, 0, 1'b0, 0));
    tbl.push_back(mk(1, 1'b0, 0, 0, 1'b1, rnd_val, 0, 1'b1, -1));
    tbl.push_back(mk(1, 1'b0, 0, 0, 1'b1, rnd_val, 0, 1'b0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst d2 out_valid", {63'd0, d2_ov}, 64'd0);
    check("rst d2 out_sop", {63'd0, d2_sop}, 64'd0);
    check("rst d2 out_data", d2_od, 64'd0);
    check("rst d2 tw_addr", {56'd0, d2_ta}, 64'd0);
    check("rst d1 out_valid", {63'd0, d1_ov}, 64'd0);
    check("rst d1 out_data", d1_od, 64'd0);
    check("rst d1 tw_addr", {56'd0, d1_ta}, 64'd0);
    rst = 1'b0;

    // pass 0 contiguous, pass 1 with a bubble after every sample
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < tbl.size(); i++) begin
        if (tbl[i].rst_before) do_reset();
        cur_sel = tbl[i].sel;
        step(1'b1, tbl[i]);
        if (pass == 1) step(1'b0, nul);
      end
      step(1'b0, nul);
    end

    // reset after three accepts, with a sample presented during reset
    cur_sel = 2;
    do_reset();
    step(1'b1, mk(2, 1'b0, 100, 1, 1'b0, 0, 0, 1'b0, -1));
    step(1'b1, mk(2, 1'b0, 200, 2, 1'b0, 0, 0, 1'b0, -1));
    step(1'b1, mk(2, 1'b0, 300, 3, 1'b0, 0, 0, 1'b0, -1));
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = {32'sd500, 32'sd5};
    @(posedge clk);
    @(negedge clk);
    check("midrst out_valid", {63'd0, d2_ov}, 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst drained out_valid", {63'd0, d2_ov}, 64'd0);
    check("midrst tw_addr", {56'd0, d2_ta}, 64'd0);
    pexp = nul;
    for (int i = basic_lo; i < basic_lo + 10; i++) step(1'b1, tbl[i]);
    step(1'b0, nul);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_r2sdf_stage.md
Name: fft_r2sdf_stage

Overview:
- One radix-2 decimation-in-frequency single-path delay-feedback (R2SDF) stage of the streaming FFT.
- Consumes one `complex_t` sample per valid cycle and produces one per valid cycle after a fixed latency.
- Performs the add/subtract butterfly against a DEPTH-entry feedback delay line and multiplies the difference path by a twiddle fetched from an external twiddle ROM.
- Stages are chained by setting DEPTH = N/2, N/4, … 1.

Parameters:
- DEPTH, 8: feedback delay length; must be a power of two ≥1; one frame = 2*DEPTH samples.
- TW_ADDR_W, 8: twiddle ROM address width.
- TW_STRIDE, 1: ROM address step per sample; equals N_total/(2*DEPTH).
- Data width and twiddle width come from `fft_pkg`: DATA_WIDTH = 32, TWIDDLE_WIDTH = 9.

Ports:
- clk, in, 1: clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input sample valid; the stage advances only on in_valid.
- in_data, in, 64 (`complex_t`): input sample; re and im are signed two's complement.
- tw_addr, out, TW_ADDR_W: twiddle ROM address; registered.
- tw_data, in, 18 (`twiddle_t`): twiddle for tw_addr, valid exactly 1 cycle after tw_addr; cos and sin are signed Q1.7 (128 = 1.0).
- out_valid, out, 1: output sample valid.
- out_data, out, 64 (`complex_t`): output sample.
- out_sop, out, 1: marks output index 0 of each frame; qualified by out_valid.

Behaviour:
- Reset: cnt=0, primed=0, pipeline valids=0, out_valid=0, out_sop=0, out_data=0, tw_addr=0. Delay-line RAM is not cleared.
- cnt:
  - Counts 0..2*DEPTH-1 on each in_valid and wraps to 0.
  - Phase A: cnt < DEPTH. Phase B: cnt ≥ DEPTH.
  - No change when in_valid=0; bubbles pass through with every register holding.
- Phase A accept:
  - Delay line writes in_data.
  - Delay-line head (a previous-frame difference d) goes to the multiplier path.
  - tw_addr ← (cnt mod DEPTH)*TW_STRIDE.
- Phase B accept:
  - f = delay-line head, x = in_data.
  - Sum s = (f+x)>>>1 goes to the bypass path (no multiply).
  - Delay line writes d = (f−x)>>>1.
  - tw_addr is unchanged (don't care).
- Butterfly arithmetic:
  - Add/subtract at DATA_WIDTH+1 bits, arithmetic shift right 1 (truncation), result fits DATA_WIDTH.
  - re and im are handled independently.
- Twiddle multiply, with W = cos − j·sin:
  - re = a·cos + b·sin; im = b·cos − a·sin.
  - Products 41 bits, sums 42 bits.
  - Arithmetic shift right 7, keep low DATA_WIDTH bits (wrap, no saturation).
- Pipeline:
  - Stage 1 registers the selected value, path select, and sop at accept.
  - Stage 2 registers the result: multiply using tw_data, or bypass.
  - out_valid rises exactly 2 cycles after the triggering in_valid, provided no bubbles intervene. With bubbles, each stage register advances every cycle (valid-tagged), so latency stays 2 cycles.
- Output order per frame: DEPTH sums (produced in phase B), then DEPTH twiddled differences (produced in the next frame's phase A).
- Priming:
  - primed sets at the first phase-B accept after reset.
  - Phase-A outputs are suppressed (out_valid=0) while primed=0; phase-B outputs are always emitted.
- out_sop = 1 on the output produced from the cnt==DEPTH accept.
- Draining: the last frame's differences stay in the delay line until a further DEPTH samples are accepted (see optional feature).
- Reset mid-frame: cnt returns to 0, primed clears, in-flight outputs are dropped (out_valid=0 next cycle), stale delay-line data is never emitted.
- DEPTH=1: phases alternate every sample; tw_addr is always 0.
- Simultaneous rst and in_valid: rst wins and the sample is discarded.

Optional Feature:
- Macro `FFT_SDF_ROUND_EN`.
- Defined:
  - Add 2^6 before the >>>7 in the twiddle multiply (round-half-up).
  - Add 1 before the >>>1 in the butterfly.
  - Widths grow by 1 internally so the added constants cannot overflow.
- Undefined: pure truncation as specified in Behaviour.
- Latency is identical in both builds.

Test Plan:
- Basic frame. DEPTH=2, TW_STRIDE=1, ROM W0=(128,0), W1=(0,128). Input two frames of re=[4,8,12,16], im=0, contiguous.
  - Outputs: 8, 12 (out_sop on 8), then (−4,0) and (0,4), then the repeat of frame 2.
  - tw_addr=0,1 during phase A.
- Bubbles. Same data with in_valid deasserted every other cycle → identical output sequence; each out_valid exactly 2 cycles after its triggering in_valid.
- Priming. First 2 accepts after reset → out_valid stays 0. First output is the sum 8 with out_sop=1.
- Reset mid-frame. Assert rst after 3 accepts, then send a fresh frame → no output derived from pre-reset data; outputs match the basic-frame test.
- Extremes. DEPTH=1, x0=(0x7FFFFFFF,0), x1=(0x7FFFFFFF,0) → sum 0x7FFFFFFF with no overflow; difference 0.
- Rounding build. Define `FFT_SDF_ROUND_EN`; DEPTH=1, W0=(128,0), inputs re=3 then 0 → sum 2 (truncating build gives 1), difference 2.
